uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter serialising parallel bytes onto a single line: start bit, data LSB-first, optional parity bit, then 1 or 2 stop bits. It is the transmit-side counterpart of the uart receive path and uses the same bit-period convention, CLOCK_BAUD_RATIO clocks per bit. Upstream logic hands it words over a valid/ready handshake, and the serial output drives the pad.

Parameters:
CLOCK_BAUD_RATIO, 400, clk cycles per serial bit; must be >= 2 (elaboration-time assertion).
BIT_WIDTH, 8, data bits per frame, 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset.
tx_data  input  BIT_WIDTH  word to send; sampled only on handshake.
tx_valid  input  1  upstream has a word.
tx_ready  output  1  block can accept a word; registered.
tx  output  1  serial line, idle high; registered.
busy  output  1  high while a frame is on the line.
done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (rst low, async): tx=1, tx_ready=1, busy=0, done=0, state IDLE, baud counter=0, shift register=0. Reset asserted mid-frame aborts the frame immediately. No done pulse is produced, and after rst rises the block is in IDLE with tx=1.
- Handshake: a transfer occurs at a posedge with tx_valid=1 and tx_ready=1 (edge N). At edge N the following happen together: tx_data is latched into the shift register, parity is computed from the latched data, tx goes 0, tx_ready goes 0, busy goes 1, state goes START, baud counter clears.
- tx_valid without tx_ready is held off. Upstream must keep tx_data stable until the handshake. tx_data and tx_valid are ignored while busy.
- Baud counter: counts 0..CLOCK_BAUD_RATIO-1, width $clog2(CLOCK_BAUD_RATIO). bit_end = (count == CLOCK_BAUD_RATIO-1). On bit_end the counter wraps to 0 and the FSM advances. Every bit therefore holds tx for exactly CLOCK_BAUD_RATIO clocks.
- FSM states and transitions:
  - IDLE: tx=1. On handshake go to START.
  - START: tx=0. On bit_end go to DATA with bit index 0 and tx = shift[0].
  - DATA: tx = current LSB. On bit_end shift right. If the bit index is BIT_WIDTH-1, go to PARITY when PARITY != 0, otherwise to STOP. Otherwise increment the index.
  - PARITY: tx = XOR of the data (even) or its inverse (odd). On bit_end go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods, using a stop counter. On the final bit_end go to IDLE, set tx_ready=1, busy=0, done=1.
- done is high for exactly one cycle: the first IDLE cycle after a frame.
- Frame length: F = (1 + BIT_WIDTH + (PARITY!=0) + STOP_BITS) * CLOCK_BAUD_RATIO clocks, from edge N to the edge that returns to IDLE.
- Back-to-back: with tx_valid held high, the earliest next handshake is at edge N+F+1. This guarantees a minimum inter-frame mark of one clock on top of the stop bits.
- tx is always driven from a flop, never combinationally, so the pad is glitch-free.
- Illegal PARITY or STOP_BITS values are rejected at elaboration.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - function calc_parity(data, mode).
- Sub-module uart_baud_gen (parameter CLOCK_BAUD_RATIO; ports clk, rst, clear, bit_end) holds the bit-period counter. It is reusable by the receive path.

Test Plan:
- Reset then idle, with CLOCK_BAUD_RATIO=4, BIT_WIDTH=8, PARITY=0, STOP_BITS=1 -> tx=1, tx_ready=1, busy=0, done=0 at every cycle while tx_valid=0.
- Send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held exactly 4 clocks. tx_ready low for 40 clocks. done pulses once, in the cycle tx_ready returns high.
- PARITY=1 sends 0xA5 -> parity bit 0, frame 11 bits = 44 clocks. PARITY=2 sends 0xA5 -> parity bit 1. PARITY=1 sends 0x07 -> parity bit 1.
- STOP_BITS=2, tx_valid held high with 0x00 then 0xFF -> second start bit begins exactly F+1 = 45 clocks after the first handshake. tx high for 9 consecutive clocks between frames (8 stop + 1 gap).
- Drive rst low during DATA bit 3 -> tx=1, busy=0, tx_ready=1 immediately (asynchronous). No done pulse. Next frame after release is bit-exact.
- Change tx_data and pulse tx_valid mid-frame -> transmitted bits unaffected, no second handshake until tx_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Data arrives zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_end is high in the last clock of every serial bit.
module uart_baud_gen #(
  parameter int CLOCK_BAUD_RATIO = 400
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLOCK_BAUD_RATIO);

  if (CLOCK_BAUD_RATIO < 2) begin : g_bad_ratio
    $error("uart_baud_gen: CLOCK_BAUD_RATIO must be >= 2");
  end

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(CLOCK_BAUD_RATIO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Handshake: a word transfers on a posedge where tx_valid && tx_ready; tx_data must be stable until then.
module uart_tx #(
  parameter int CLOCK_BAUD_RATIO = 400,
  parameter int BIT_WIDTH        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  import uart_pkg::*;

  if (BIT_WIDTH < 5 || BIT_WIDTH > 9) begin : g_bad_width
    $error("uart_tx: BIT_WIDTH must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state;
  logic [BIT_WIDTH-1:0] shift;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 par_bit;
  logic                 bit_end;
  logic                 hs;
  logic                 baud_clear;

  assign hs         = tx_valid && tx_ready;
  // Holding the counter clear in IDLE makes the start bit exactly one period long.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .CLOCK_BAUD_RATIO(CLOCK_BAUD_RATIO)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            shift    <= tx_data;
            par_bit  <= calc_parity(9'(tx_data), PARITY);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 4'(BIT_WIDTH - 1)) begin
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= uart_pkg::PARITY;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shift[1];
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_end) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
